// File: rtl/control_sequencer_pkg.sv
// Shared definitions for control_sequencer: control-word layout, constant words,
// microstate encodings, instruction classes and the decoder output bundle.
package control_sequencer_pkg;

  localparam int CW_W   = 29;
  localparam int REG_W  = 5;
  localparam int FSEL_W = 5;
  localparam int PSEL_W = 2;
  localparam int DSEL_W = 2;

  localparam int SL_O    = 0;
  localparam int PCSEL_O = 1;
  localparam int BSEL_O  = 2;
  localparam int DSEL_O  = 3;
  localparam int RAMW_O  = 5;
  localparam int REGW_O  = 6;
  localparam int FSEL_O  = 7;
  localparam int SB_O    = 12;
  localparam int SA_O    = 17;
  localparam int DA_O    = 22;
  localparam int PSEL_O  = 27;

  localparam logic [PSEL_W-1:0] P_HOLD = 2'b00;
  localparam logic [PSEL_W-1:0] P_INC  = 2'b01;
  localparam logic [PSEL_W-1:0] P_BR   = 2'b10;
  localparam logic [PSEL_W-1:0] P_CB   = 2'b11;

  localparam logic [DSEL_W-1:0] D_ALU = 2'b00;
  localparam logic [DSEL_W-1:0] D_MEM = 2'b01;

  localparam logic [FSEL_W-1:0] F_AND   = 5'h00;
  localparam logic [FSEL_W-1:0] F_ORR   = 5'h01;
  localparam logic [FSEL_W-1:0] F_ADD   = 5'h02;
  localparam logic [FSEL_W-1:0] F_SUB   = 5'h03;
  localparam logic [FSEL_W-1:0] F_EOR   = 5'h04;
  localparam logic [FSEL_W-1:0] F_PASSB = 5'h07;

  localparam logic [CW_W-1:0] HOLD_WORD = '0;
  localparam logic [CW_W-1:0] NOP_WORD  = {P_INC, {(CW_W-PSEL_W){1'b0}}};

  typedef enum logic [1:0] {
    ST_EXEC = 2'b00,
    ST_MEM  = 2'b01,
    ST_RSVD = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    CLS_IMM,
    CLS_REG,
    CLS_MEM,
    CLS_BR,
    CLS_UNDEF
  } cls_e;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic [63:0]     k;
    state_e          nx;
  } dec_out_t;

  function automatic logic [CW_W-1:0] pack_cw(
    input logic [PSEL_W-1:0] psel,
    input logic [REG_W-1:0]  da,
    input logic [REG_W-1:0]  sa,
    input logic [REG_W-1:0]  sb,
    input logic [FSEL_W-1:0] fsel,
    input logic              regw,
    input logic              ramw,
    input logic [DSEL_W-1:0] dsel,
    input logic              bsel,
    input logic              pcsel,
    input logic              sl
  );
    return {psel, da, sa, sb, fsel, regw, ramw, dsel, bsel, pcsel, sl};
  endfunction

endpackage

// File: rtl/control_sequencer_classifier.sv
// Opcode classifier: maps instruction[28:25] onto an instruction class, first
// match wins so overlapping patterns resolve in a fixed priority.
module opcode_classifier
  import control_sequencer_pkg::*;
(
  input  logic [3:0] i_op,
  output cls_e       o_cls
);

  always_comb begin
    o_cls = CLS_UNDEF;
    priority casez (i_op)
      4'b100?: o_cls = CLS_IMM;
      4'b101?: o_cls = CLS_BR;
      4'b?1?0: o_cls = CLS_MEM;
      4'b?101: o_cls = CLS_REG;
      default: o_cls = CLS_UNDEF;
    endcase
  end

endmodule

// File: rtl/control_sequencer_decoders.sv
// Per-class decoders (immediate-ALU, register-ALU, memory, branch); each turns
// the effective instruction into a control word, a K constant and a next state.
module imm_alu_decoder
  import control_sequencer_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_out_t    o_dec
);

  logic w_unused;
  assign w_unused = ^{i_instr[31], i_instr[28:22]};

  always_comb begin
    o_dec.cw = pack_cw(P_INC, i_instr[4:0], i_instr[9:5], 5'd0,
                       i_instr[30] ? F_SUB : F_ADD, 1'b1, 1'b0, D_ALU,
                       1'b1, 1'b0, i_instr[29]);
    o_dec.k  = {52'd0, i_instr[21:10]};
    o_dec.nx = ST_EXEC;
  end

endmodule

module reg_alu_decoder
  import control_sequencer_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_out_t    o_dec
);

  logic [FSEL_W-1:0] w_fsel;
  logic              w_unused;
  assign w_unused = ^{i_instr[31], i_instr[28:25], i_instr[23:21]};

  always_comb begin
    // Bit 24 splits arithmetic (ADD/SUB) from logical register forms.
    if (i_instr[24]) begin
      w_fsel = i_instr[30] ? F_SUB : F_ADD;
    end else begin
      unique case (i_instr[30:29])
        2'b01:   w_fsel = F_ORR;
        2'b10:   w_fsel = F_EOR;
        default: w_fsel = F_AND;
      endcase
    end
    o_dec.cw = pack_cw(P_INC, i_instr[4:0], i_instr[9:5], i_instr[20:16],
                       w_fsel, 1'b1, 1'b0, D_ALU, 1'b0, 1'b0, i_instr[29]);
    o_dec.k  = {58'd0, i_instr[15:10]};
    o_dec.nx = ST_EXEC;
  end

endmodule

module mem_decoder
  import control_sequencer_pkg::*;
(
  input  logic [31:0] i_instr,
  input  state_e      i_state,
  output dec_out_t    o_dec
);

  logic w_last;
  logic w_load;
  logic w_unused;
  assign w_unused = ^{i_instr[31:23], i_instr[21], i_instr[11:10]};
  assign w_last   = (i_state == ST_MEM);
  assign w_load   = i_instr[22];

  // First cycle forms the address with PC held; second cycle commits and advances.
  always_comb begin
    o_dec.cw = pack_cw(w_last ? P_INC : P_HOLD, i_instr[4:0], i_instr[9:5],
                       i_instr[4:0], F_ADD, w_last & w_load, w_last & ~w_load,
                       D_MEM, 1'b1, 1'b0, 1'b0);
    o_dec.k  = {{55{i_instr[20]}}, i_instr[20:12]};
    o_dec.nx = w_last ? ST_EXEC : ST_MEM;
  end

endmodule

module br_decoder
  import control_sequencer_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [3:0]  i_status,
  output dec_out_t    o_dec
);

  logic              w_ok;
  logic [PSEL_W-1:0] w_psel;
  logic              w_unused;
  assign w_unused = ^{i_instr[31], i_instr[28:26]};

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] s);
    logic v, cy, n, z, r;
    {v, cy, n, z} = s;
    unique case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? ~r : r;
  endfunction

  assign w_ok = cond_ok(i_instr[3:0], i_status);

  // Bit 30 marks B.cond, bit 29 marks CBZ/CBNZ (resolved in the PC unit), else B.
  always_comb begin
    if (i_instr[30]) begin
      w_psel  = w_ok ? P_BR : P_INC;
      o_dec.k = {{45{i_instr[23]}}, i_instr[23:5]};
    end else if (i_instr[29]) begin
      w_psel  = P_CB;
      o_dec.k = {{45{i_instr[23]}}, i_instr[23:5]};
    end else begin
      w_psel  = P_BR;
      o_dec.k = {{38{i_instr[25]}}, i_instr[25:0]};
    end
    o_dec.cw = pack_cw(w_psel, 5'd0, 5'd0, i_instr[4:0], F_PASSB, 1'b0, 1'b0,
                       D_ALU, 1'b0, 1'b1, 1'b0);
    o_dec.nx = ST_EXEC;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control sequencer: microstate/IR registers, class routing, stall
// gating and retire counter. Define CTRL_ILLEGAL_TRAP_EN to halt on undefined opcodes.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            instruction,
  input  logic                   stall,
  input  logic [3:0]             status,
  output logic [CW_W-1:0]        controlWord,
  output logic [63:0]            K,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] instrCount,
  output logic                   illegal
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

  state_e                 r_state;
  state_e                 w_next;
  logic [31:0]            r_ir;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            w_eff;
  cls_e                   w_cls;
  dec_out_t               w_imm, w_reg, w_mem, w_br, w_dec;
  logic                   w_undef;
  logic                   w_halt;
  logic                   w_adv;

  assign w_eff = (r_state == ST_EXEC) ? instruction : r_ir;

  opcode_classifier u_cls (.i_op(w_eff[28:25]), .o_cls(w_cls));
  imm_alu_decoder   u_imm (.i_instr(w_eff), .o_dec(w_imm));
  reg_alu_decoder   u_reg (.i_instr(w_eff), .o_dec(w_reg));
  mem_decoder       u_mem (.i_instr(w_eff), .i_state(r_state), .o_dec(w_mem));
  br_decoder        u_br  (.i_instr(w_eff), .i_status(status), .o_dec(w_br));

  // Reserved state 10 (and 11 when not halting) decodes as undefined and returns to 00.
  always_comb begin
    w_dec   = '{cw: NOP_WORD, k: 64'd0, nx: ST_EXEC};
    w_undef = 1'b0;
    if (r_state[1]) begin
      w_undef = 1'b1;
    end else begin
      case (w_cls)
        CLS_IMM: w_dec = w_imm;
        CLS_REG: w_dec = w_reg;
        CLS_MEM: w_dec = w_mem;
        CLS_BR:  w_dec = w_br;
        default: w_undef = 1'b1;
      endcase
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_next = w_undef ? ST_HALT : w_dec.nx;
`else
    w_next = w_dec.nx;
`endif
  end

  always_comb begin
    controlWord = w_dec.cw;
    K           = w_dec.k;
    if (reset || w_halt) begin
      controlWord = HOLD_WORD;
      K           = 64'd0;
    end else if (stall) begin
      controlWord[PSEL_O +: PSEL_W] = P_HOLD;
      controlWord[REGW_O]           = 1'b0;
      controlWord[RAMW_O]           = 1'b0;
    end
  end

  assign w_adv = ~stall & ~w_halt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_EXEC;
      r_ir    <= 32'd0;
      r_count <= '0;
    end else if (w_adv) begin
      r_state <= w_next;
      if (r_state == ST_EXEC && w_next != ST_EXEC) r_ir <= instruction;
      if (w_next == ST_EXEC) r_count <= r_count + CNT_ONE;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_illegal <= 1'b0;
    else if (w_adv && w_undef) r_illegal <= 1'b1;
  end
  assign w_halt  = (r_state == ST_HALT);
  assign illegal = r_illegal;
`else
  assign w_halt  = 1'b0;
  assign illegal = 1'b0;
`endif

  assign state      = r_state;
  assign instrCount = r_count;

endmodule
